// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//
// Round-robin arbiter that shares one registered W-bit output slot among
// N_REQ valid/ready requesters. A combinational scan picks the first valid
// requester after the last-granted index (ptr), so ptr itself is scanned last.
// When the slot is free (empty or draining this cycle), the winner's beat is
// registered into out_data/out_sel/out_valid and ptr moves to the winner.
//
// Optional feature, enabled by defining RR_MUX_ARBITER_PKT_LOCK_EN:
// packet locking. A beat accepted with in_last=0 locks the grant onto its
// requester until that requester delivers a beat with in_last=1. While
// locked, in_ready goes only to the locked requester, even if its in_valid is low.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-high reset
//   in_valid   [N_REQ]      per-requester valid
//   in_data    [N_REQ*W]    packed data, requester k at [k*W +: W]
//   in_last    [N_REQ]      per-requester end-of-packet (lock build only)
//   in_ready   [N_REQ]      per-requester ready, combinational, at most one set
//   out_valid               registered output valid
//   out_data   [W]          registered output data
//   out_sel    [SEL_W]      registered index of the requester behind out_data
//   out_last                registered end-of-packet (lock build only)
//   out_ready               downstream ready
module rr_mux_arbiter #(
  parameter int  N_REQ = 4,
  parameter int  W     = 4,
  localparam int SEL_W = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   in_valid,
  input  logic [N_REQ*W-1:0] in_data,
`ifdef RR_MUX_ARBITER_PKT_LOCK_EN
  input  logic [N_REQ-1:0]   in_last,
  output logic               out_last,
`endif
  output logic [N_REQ-1:0]   in_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  logic [SEL_W-1:0] ptr;       // last-granted requester
  logic             slot_free; // output slot can take a beat this cycle
  logic [SEL_W-1:0] win;       // requester offered in_ready this cycle
  logic             have_win;  // win is meaningful
  logic             accept;    // a beat transfers into the slot at the next edge

`ifdef RR_MUX_ARBITER_PKT_LOCK_EN
  // While locked, out_sel always holds the locked requester (it supplied the
  // last accepted beat), so it doubles as the lock index.
  logic lock;
`endif

  // NOTE: every signal assigned in always_comb gets a default at the top of
  // the block so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    slot_free = !out_valid || out_ready;
    win       = ptr;
    have_win  = 1'b0;
`ifdef RR_MUX_ARBITER_PKT_LOCK_EN
    if (lock) begin
      // Scan bypassed: ready goes to the locked requester unconditionally.
      win      = out_sel;
      have_win = 1'b1;
    end else
`endif
    begin
      // Scan ptr+1 .. ptr+N_REQ (mod N_REQ); the last candidate is ptr itself.
      for (int i = 1; i <= N_REQ; i++) begin
        if (!have_win && in_valid[SEL_W'((int'(ptr) + i) % N_REQ)]) begin
          have_win = 1'b1;
          win      = SEL_W'((int'(ptr) + i) % N_REQ);
        end
      end
    end

    in_ready = '0;
    if (have_win && slot_free) begin
      in_ready[win] = 1'b1;
    end
    // Under lock the winner may not be valid; only a real valid beat transfers.
    accept = have_win && slot_free && in_valid[win];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SEL_W'(N_REQ - 1);
`ifdef RR_MUX_ARBITER_PKT_LOCK_EN
      out_last  <= 1'b0;
      lock      <= 1'b0;
`endif
    end else if (slot_free) begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_data[win*W +: W];
        out_sel   <= win;
        ptr       <= win;
`ifdef RR_MUX_ARBITER_PKT_LOCK_EN
        out_last  <= in_last[win];
        lock      <= !in_last[win];
`endif
      end else begin
        // Slot drained (or was empty) with nothing to take: go idle, hold the rest.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Round-robin arbiter that shares one registered W-bit output channel among N_REQ requesters. Each requester has a valid/ready handshake. The arbiter generates the select for an N_REQ:1 data mux and registers the chosen beat into a single output slot. It sits between several producer blocks and one downstream consumer; the downstream side also uses valid/ready.

Parameters:
N_REQ, 4, number of requesters; legal range 2..8.
W, 4, data width per requester.
SEL_W, $clog2(N_REQ), width of the select/grant index (derived; not overridden).

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  N_REQ  per-requester valid; bit k belongs to requester k.
in_data  input  N_REQ*W  packed data; requester k occupies bits [k*W +: W].
in_ready  output  N_REQ  per-requester ready; combinational; at most one bit set.
out_valid  output  1  registered output valid.
out_data  output  W  registered output data.
out_sel  output  SEL_W  registered index of the requester that supplied out_data.
out_ready  input  1  downstream ready.

Behaviour:
- Reset (async, while rst=1): out_valid=0, out_data=0, out_sel=0, last-grant pointer ptr=N_REQ-1. Requester 0 therefore has highest priority first.
- slot_free = !out_valid || out_ready (combinational).
- Winner: first k with in_valid[k]=1, scanning ptr+1, ptr+2, ... modulo N_REQ. ptr itself is scanned last.
- in_ready[winner] = slot_free; all other in_ready bits = 0.
  - in_ready may depend combinationally on in_valid and out_ready.
  - in_valid must not depend on in_ready.
- Posedge with slot_free and a winner present: out_data<=in_data[winner], out_sel<=winner, out_valid<=1, ptr<=winner.
- Posedge with slot_free and no in_valid set: out_valid<=0. out_data, out_sel and ptr hold.
- Posedge with !slot_free (out_valid=1, out_ready=0): all registers hold; in_ready=0.
- Latency: a beat accepted in cycle t appears on out_* in cycle t+1.
- Throughput: one beat per cycle when out_ready is held high (back-to-back accept while draining).
- Fairness: with all requesters continuously valid and out_ready=1, grants rotate 0,1,..,N_REQ-1,0,...
  - Any continuously valid requester is granted within N_REQ accepted beats.
- Pointer wrap: ptr=N_REQ-1 wraps the scan start to 0.
- Requester dropping in_valid before being granted is legal. The arbiter simply skips it; no state is kept per requester.
- Reset mid-operation: any held beat is discarded (out_valid=0 immediately); ptr returns to N_REQ-1.
- No X propagation on control: when no in_valid bit is set, in_ready=0 and out_valid is not set to 1. Data bits pass through unchecked.

Optional Feature:
Macro RR_MUX_ARBITER_PKT_LOCK_EN.
- Defined:
  - Adds port in_last, input, N_REQ bits; per-requester end-of-packet flag.
  - Adds port out_last, output, 1 bit; registered alongside out_data; reset 0.
  - Adds a lock flag, reset 0. Accepting a beat with in_last[winner]=0 sets lock and holds the grant on that requester. The round-robin scan is bypassed and in_ready goes only to the locked index, even if its in_valid is low.
  - Accepting a beat with in_last=1 clears lock and updates ptr.
  - Reset clears lock.
- Undefined: no in_last/out_last ports; every beat is arbitrated independently, as described above.

Test Plan:
- Reset; in_valid=4'b1111, data d0..d3 = a,b,c,d, out_ready=1. Expect out_sel sequence 0,1,2,3,0 and out_data a,b,c,d,a. Expect one in_ready per cycle and out_valid=1 from the cycle after the first accept.
- in_valid=4'b0101, out_ready=1, from reset. Expect grants 0,2,0,2 and in_ready[1]=in_ready[3]=0 always.
- Accept a beat (out_valid=1), then out_ready=0 for 3 cycles with in_valid=4'b1111. Expect in_ready=0 and out_* stable. Raising out_ready gives the next grant to ptr+1 in the same cycle.
- Single requester 3 valid after reset. Expect grant 3, then ptr=3; next grant 3 again with no idle cycle. Dropping in_valid gives out_valid=0 one cycle after the last drain.
- Assert rst asynchronously mid-stream (out_valid=1). Expect out_valid, out_data and out_sel = 0 without a clock edge. After release, the first grant goes to requester 0.
- PKT_LOCK_EN: requester 1 sends 3 beats (in_last=0,0,1) while 0, 2 and 3 are valid. Expect out_sel=1 for all 3 beats and out_last=0,0,1, then a grant to 2.
